// File: rtl/pipe_stage_skid.sv
// Valid/ready pipeline register with an optional two-entry skid buffer,
// synchronous flush and a saturating stall-cycle counter.
//
// state | meaning
// ------+-----------------------------------------------------------
// EMPTY | nothing held, out_valid=0
// MAIN  | one payload in main register, presented on out_data
// FULL  | main presented, skid holds the next payload (SKID=1 only)
module pipe_stage_skid #(
  parameter int                DATA_W  = 32*5+8,
  parameter bit                SKID    = 1'b1,
  parameter int                CNT_W   = 16,
  parameter logic [DATA_W-1:0] RST_VAL = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  // Encoding equals the number of entries held, so occupancy is the state itself.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    MAIN  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic [CNT_W-1:0]  stall_q;
  logic              accept;
  logic              consume;

  assign out_valid = (state_q != EMPTY);
  assign out_data  = main_q;
  assign occupancy = state_q;
  assign stall_cnt = stall_q;
  assign consume   = out_valid & out_ready;
  assign accept    = in_valid & in_ready;

  if (SKID) begin : g_reg_ready
    logic ready_q;

    // Registered so that out_ready never reaches in_ready combinationally.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        ready_q <= 1'b1;
      end else begin
        ready_q <= (state_d != FULL);
      end
    end

    assign in_ready = ready_q;
  end else begin : g_comb_ready
    assign in_ready = ~out_valid | out_ready;
  end

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;

    case (state_q)
      EMPTY: begin
        if (accept) begin
          state_d = MAIN;
          main_d  = in_data;
        end
      end
      MAIN: begin
        if (accept && consume) begin
          main_d = in_data;
        end else if (accept && SKID) begin
          state_d = FULL;
          skid_d  = in_data;
        end else if (consume) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (consume) begin
          state_d = MAIN;
          main_d  = skid_q;
          skid_d  = RST_VAL;
        end
      end
      default: begin
        state_d = EMPTY;
      end
    endcase

    // Flush wins over any same-cycle accept or consume.
    if (flush) begin
      state_d = EMPTY;
      main_d  = RST_VAL;
      skid_d  = RST_VAL;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= EMPTY;
      main_q  <= RST_VAL;
      skid_q  <= RST_VAL;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_q <= '0;
    end else if (out_valid && !out_ready && (stall_q != {CNT_W{1'b1}})) begin
      stall_q <= stall_q + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: a skid instance and a single-entry instance share
// stimulus and are checked every cycle against a small FIFO model.
module tb_pipe_stage_skid;

  localparam logic [15:0] RST = 16'hA5A5;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, out_ready;
  logic [15:0] in_data;

  logic        s1_in_ready, s1_out_valid, s0_in_ready, s0_out_valid;
  logic [15:0] s1_out_data, s0_out_data;
  logic [1:0]  s1_occ, s0_occ;
  logic [3:0]  s1_stall;
  logic [15:0] s0_stall;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  pipe_stage_skid #(.DATA_W(16), .SKID(1'b1), .CNT_W(4), .RST_VAL(RST)) u_s1 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(s1_in_ready), .in_data(in_data),
    .out_valid(s1_out_valid), .out_ready(out_ready), .out_data(s1_out_data),
    .occupancy(s1_occ), .stall_cnt(s1_stall)
  );

  pipe_stage_skid #(.DATA_W(16), .SKID(1'b0), .CNT_W(16), .RST_VAL(RST)) u_s0 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(s0_in_ready), .in_data(in_data),
    .out_valid(s0_out_valid), .out_ready(out_ready), .out_data(s0_out_data),
    .occupancy(s0_occ), .stall_cnt(s0_stall)
  );

  // Reference model: index 0 = single entry (capacity 1), index 1 = skid (capacity 2).
  int          m_cnt   [2];
  logic [15:0] m_e     [2][2];
  int          m_stall [2];
  bit          m_known [2];
  bit          m_rdy1;
  int          smax    [2] = '{65535, 15};

  task automatic chk(input string name, input int inst, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[s%0d] t=%0t actual=%h required=%h", name, inst, $time, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 2; i++) begin
      m_cnt[i]   = 0;
      m_stall[i] = 0;
      m_known[i] = 1'b1;
    end
    m_rdy1 = 1'b1;
  endtask

  initial begin
    model_clear();
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        model_clear();
      end else begin
        for (int i = 0; i < 2; i++) begin
          bit rdy, acc, con;
          rdy = (i == 1) ? m_rdy1 : ((m_cnt[0] == 0) || out_ready);
          acc = in_valid && rdy;
          con = (m_cnt[i] > 0) && out_ready;
          if ((m_cnt[i] > 0) && !out_ready && (m_stall[i] < smax[i])) m_stall[i]++;
          if (flush) begin
            m_cnt[i]   = 0;
            m_known[i] = 1'b1;
          end else begin
            if (con) begin
              m_e[i][0] = m_e[i][1];
              m_cnt[i]--;
            end
            if (acc && (m_cnt[i] < 2)) begin
              m_e[i][m_cnt[i]] = in_data;
              m_cnt[i]++;
              m_known[i] = 1'b0;
            end
          end
        end
        m_rdy1 = (m_cnt[1] < 2);
      end
    end
  end

  // Per-cycle comparison against the model.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
        logic        ov, rdy, exp_rdy;
        logic [1:0]  occ;
        logic [15:0] dat, st;
        if (i == 1) begin
          ov = s1_out_valid; rdy = s1_in_ready; occ = s1_occ;
          dat = s1_out_data; st = {12'd0, s1_stall};
          exp_rdy = m_rdy1;
        end else begin
          ov = s0_out_valid; rdy = s0_in_ready; occ = s0_occ;
          dat = s0_out_data; st = s0_stall;
          exp_rdy = (m_cnt[0] == 0) || out_ready;
        end
        chk("out_valid", i, 32'(ov), 32'(m_cnt[i] > 0));
        chk("occupancy", i, 32'(occ), 32'(m_cnt[i]));
        chk("in_ready", i, 32'(rdy), 32'(exp_rdy));
        chk("stall_cnt", i, 32'(st), 32'(m_stall[i]));
        if (m_cnt[i] > 0) chk("out_data", i, 32'(dat), 32'(m_e[i][0]));
        else if (m_known[i]) chk("out_data_rst", i, 32'(dat), 32'(RST));
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    cyc(2);
    reset = 1'b0;
    cyc(1);
    chk("rst_in_ready", 1, 32'(s1_in_ready), 32'd1);
    chk("rst_out_valid", 1, 32'(s1_out_valid), 32'd0);
    chk("rst_occ", 1, 32'(s1_occ), 32'd0);
    chk("rst_out_data", 1, 32'(s1_out_data), 32'(RST));
    chk("rst_stall", 1, 32'(s1_stall), 32'd0);

    // Streaming at full rate, 1-cycle latency.
    out_ready = 1'b1; in_valid = 1'b1; in_data = 16'h0011;
    cyc(1);
    chk("t1_d11", 1, 32'(s1_out_data), 32'h11);
    chk("t1_occ", 1, 32'(s1_occ), 32'd1);
    chk("t1_d11", 0, 32'(s0_out_data), 32'h11);
    in_data = 16'h0022; cyc(1);
    chk("t1_d22", 1, 32'(s1_out_data), 32'h22);
    in_data = 16'h0033; cyc(1);
    chk("t1_d33", 1, 32'(s1_out_data), 32'h33);
    chk("t1_d33", 0, 32'(s0_out_data), 32'h33);
    in_valid = 1'b0; cyc(1);
    chk("t1_empty", 1, 32'(s1_out_valid), 32'd0);
    chk("t1_stall", 1, 32'(s1_stall), 32'd0);

    // Back-pressure fills the skid buffer.
    out_ready = 1'b0; in_valid = 1'b1; in_data = 16'h000A; cyc(1);
    chk("t2_occ1", 1, 32'(s1_occ), 32'd1);
    chk("t2_rdy1", 1, 32'(s1_in_ready), 32'd1);
    in_data = 16'h000B; cyc(1);
    chk("t2_occ2", 1, 32'(s1_occ), 32'd2);
    chk("t2_rdy0", 1, 32'(s1_in_ready), 32'd0);
    chk("t2_stall1", 1, 32'(s1_stall), 32'd1);
    in_data = 16'h000C; cyc(2);
    chk("t2_stall3", 1, 32'(s1_stall), 32'd3);
    chk("t2_headA", 1, 32'(s1_out_data), 32'hA);
    out_ready = 1'b1; cyc(1);
    chk("t2_B", 1, 32'(s1_out_data), 32'hB);
    chk("t2_B_occ", 1, 32'(s1_occ), 32'd1);
    cyc(1);
    chk("t2_C", 1, 32'(s1_out_data), 32'hC);
    in_valid = 1'b0; cyc(1);
    chk("t2_empty", 1, 32'(s1_out_valid), 32'd0);
    chk("t2_stall_end", 1, 32'(s1_stall), 32'd3);

    // Flush from FULL discards the same-cycle input.
    out_ready = 1'b0; in_valid = 1'b1; in_data = 16'h0001; cyc(1);
    in_data = 16'h0002; cyc(1);
    chk("t3_full", 1, 32'(s1_occ), 32'd2);
    flush = 1'b1; in_data = 16'hDEAD; cyc(1);
    flush = 1'b0; in_valid = 1'b0;
    chk("t3_ov", 1, 32'(s1_out_valid), 32'd0);
    chk("t3_occ", 1, 32'(s1_occ), 32'd0);
    chk("t3_data", 1, 32'(s1_out_data), 32'(RST));
    chk("t3_rdy", 1, 32'(s1_in_ready), 32'd1);
    chk("t3_ov", 0, 32'(s0_out_valid), 32'd0);
    out_ready = 1'b1; cyc(3);
    chk("t3_no_dead", 1, 32'(s1_out_valid), 32'd0);

    // Stall counter saturation.
    reset = 1'b1; cyc(1);
    reset = 1'b0; in_valid = 1'b1; in_data = 16'h0055; out_ready = 1'b0; cyc(1);
    in_valid = 1'b0; cyc(5);
    chk("t4_stall5", 1, 32'(s1_stall), 32'd5);
    chk("t4_stall5", 0, 32'(s0_stall), 32'd5);
    cyc(15);
    chk("t4_sat15", 1, 32'(s1_stall), 32'd15);
    chk("t4_stall20", 0, 32'(s0_stall), 32'd20);

    // Asynchronous reset between edges while FULL.
    in_valid = 1'b1; in_data = 16'h0066; cyc(1);
    chk("t5_full", 1, 32'(s1_occ), 32'd2);
    in_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("t5_ov", 1, 32'(s1_out_valid), 32'd0);
    chk("t5_stall", 1, 32'(s1_stall), 32'd0);
    chk("t5_occ", 1, 32'(s1_occ), 32'd0);
    chk("t5_data", 1, 32'(s1_out_data), 32'(RST));
    chk("t5_ov", 0, 32'(s0_out_valid), 32'd0);
    #1 reset = 1'b0;
    out_ready = 1'b1; cyc(2);
    chk("t5_idle", 1, 32'(s1_out_valid), 32'd0);
    in_valid = 1'b1; in_data = 16'h0077; cyc(1);
    chk("t5_first", 1, 32'(s1_out_data), 32'h77);
    chk("t5_first", 0, 32'(s0_out_data), 32'h77);
    in_valid = 1'b0; cyc(1);

    // Random traffic with occasional flush.
    for (int k = 0; k < 1000; k++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = 16'($urandom);
      out_ready = 1'($urandom_range(0, 1));
      flush     = ($urandom_range(0, 31) == 0);
      cyc(1);
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    cyc(3);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
